record_screen_ctrl: RTL and testbench

Sequences the OLED record user flow on the 96x64 RGB565 panel, as follows.
- Shows the record-start instruction screen.
- Detects a press-and-hold of the centre button, and shows hold progress as a bar.
- Enables recording for a bounded time, then shows a completion screen before returning to start.
- Sits between the OLED display driver (pixel_index, frame_begin) and the per-screen pixel generators.
- Converts pixel_index to x/y for those generators and muxes their oled_data, switching screens only on frame boundaries.

---
 rtl/record_screen_ctrl.sv | 136 +++++++++++++
 tb/tb_record_screen_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/record_screen_ctrl.sv
// rtl/record_screen_ctrl.sv - OLED record flow sequencer: start, hold-to-arm, record, done screens
module record_screen_ctrl #(
  parameter int HOLD_FRAMES = 30,
  parameter int REC_CYCLES  = 100000000,
  parameter int DONE_FRAMES = 60,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_c,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [15:0] start_data,
  input  logic [15:0] rec_data,
  input  logic [15:0] done_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [15:0] oled_data,
  output logic        rec_en,
  output logic        rec_done,
  output logic [1:0]  screen_sel
);

  localparam int DONE_W = $clog2(DONE_FRAMES + 1);

  typedef enum logic [1:0] {ST_START, ST_ARMING, ST_RECORD, ST_DONE} state_t;

  state_t            state;
  logic [6:0]        hold_cnt;
  logic [CNT_W-1:0]  rec_cnt;
  logic [DONE_W-1:0] done_cnt;
  logic              btn_prev;

  logic              btn_rise;
  logic [6:0]        hold_inc;
  logic [DONE_W-1:0] done_inc;
  logic              in_range;
  logic              bar_px;

  assign btn_rise = btn_c & ~btn_prev;
  assign hold_inc = hold_cnt + 7'd1;
  assign done_inc = done_cnt + DONE_W'(1);

  assign in_range = pixel_index < 13'd6144;
  assign x        = in_range ? 7'(pixel_index % 13'd96) : 7'd0;
  assign y        = in_range ? 6'(pixel_index / 13'd96) : 6'd0;

  // Hold progress is drawn along the bottom row only while the start screen is up.
  assign bar_px = (screen_sel == 2'd0) && (state == ST_ARMING) &&
                  (y == 6'd63) && (x < hold_cnt);

  always_comb begin
    oled_data = start_data;
    if (!in_range) begin
      oled_data = 16'h0000;
    end else if (bar_px) begin
      oled_data = 16'h07E0;
    end else begin
      case (screen_sel)
        2'd1:    oled_data = rec_data;
        2'd2:    oled_data = done_data;
        default: oled_data = start_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_START;
      hold_cnt   <= 7'd0;
      rec_cnt    <= '0;
      done_cnt   <= '0;
      btn_prev   <= 1'b0;
      rec_en     <= 1'b0;
      rec_done   <= 1'b0;
      screen_sel <= 2'd0;
    end else begin
      btn_prev <= btn_c;
      rec_done <= 1'b0;

      // Screen changes only at frame start so a frame is never drawn from two sources.
      if (frame_begin) begin
        case (state)
          ST_RECORD: screen_sel <= 2'd1;
          ST_DONE:   screen_sel <= 2'd2;
          default:   screen_sel <= 2'd0;
        endcase
      end

      case (state)
        ST_START: begin
          if (btn_rise) begin
            state    <= ST_ARMING;
            hold_cnt <= 7'd0;
          end
        end
        ST_ARMING: begin
          if (!btn_c) begin
            state    <= ST_START;
            hold_cnt <= 7'd0;
          end else if (frame_begin) begin
            hold_cnt <= hold_inc;
            if (hold_inc == 7'(HOLD_FRAMES)) begin
              state   <= ST_RECORD;
              rec_cnt <= '0;
              rec_en  <= 1'b1;
            end
          end
        end
        ST_RECORD: begin
          if ((rec_cnt == CNT_W'(REC_CYCLES - 1)) || btn_rise) begin
            state    <= ST_DONE;
            rec_en   <= 1'b0;
            rec_done <= 1'b1;
            done_cnt <= '0;
          end else begin
            rec_cnt <= rec_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (frame_begin) begin
            done_cnt <= done_inc;
            if (done_inc == DONE_W'(DONE_FRAMES)) begin
              state    <= ST_START;
              hold_cnt <= 7'd0;
              rec_cnt  <= '0;
              done_cnt <= '0;
            end
          end
        end
        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_record_screen_ctrl.sv
// tb/tb_record_screen_ctrl.sv - scoreboard bench for record_screen_ctrl against a timeline model
module tb_record_screen_ctrl;

  localparam int FP    = 50;
  localparam int HOLD  = 3;
  localparam int REC   = 20;
  localparam int DONEF = 2;

  localparam int P_START = 0;
  localparam int P_ARM   = 1;
  localparam int P_REC   = 2;
  localparam int P_DONE  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_c;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [15:0] start_data, rec_data, done_data;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_data;
  logic        rec_en, rec_done;
  logic [1:0]  screen_sel;

  record_screen_ctrl #(
    .HOLD_FRAMES(HOLD), .REC_CYCLES(REC), .DONE_FRAMES(DONEF), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .btn_c(btn_c), .frame_begin(frame_begin),
    .pixel_index(pixel_index), .start_data(start_data), .rec_data(rec_data),
    .done_data(done_data), .x(x), .y(y), .oled_data(oled_data),
    .rec_en(rec_en), .rec_done(rec_done), .screen_sel(screen_sel)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int data; int en; int done; int sel; } probe_t;
  typedef struct { int cyc; int len; } done_t;
  typedef struct { int cyc; int sel; } scr_t;

  probe_t probe_q[$];
  done_t  done_q[$];
  scr_t   scr_q[$];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_rst = 0;
  int   run = 0;
  int   last_sel = 0;
  bit   mon_on = 1'b0;
  logic probe = 1'b0;

  // Current attempt timeline (cycle numbers)
  int a_kind = 0;
  int a_p = 1 << 30;
  int a_f3 = 1 << 30;
  int a_rl = 0, a_a = 0, a_q = 0, a_l = 0, a_d = -1, a_g2 = -1, a_rel = 0, a_r = 0, a_end = 0;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic int phase_at(input int n);
    if (n <= a_p) return P_START;
    if (a_kind == 0) return (n <= a_rl) ? P_ARM : P_START;
    if (n <= a_f3) return P_ARM;
    if (n <= a_l) return P_REC;
    if (a_kind == 3) return P_START;
    if (n <= a_g2) return P_DONE;
    return P_START;
  endfunction

  function automatic int sel_at(input int n);
    int f;
    int ph;
    f = ((n - 1) / FP) * FP;
    if (f <= last_rst) return 0;
    ph = phase_at(f);
    if (ph == P_REC) return 1;
    if (ph == P_DONE) return 2;
    return 0;
  endfunction

  function automatic int hold_at(input int n);
    return (n - 1) / FP - a_p / FP;
  endfunction

  function automatic logic btn_at(input int n);
    if (n < a_p) return 1'b0;
    case (a_kind)
      0:       return n < a_rl;
      1:       return n < a_rel;
      2:       return (n < a_a) || (n >= a_q && n < a_rel);
      default: return n < a_r;
    endcase
  endfunction

  task automatic step(input logic b, input logic rst, input bit pr, input int fixed);
    int pix;
    int ph;
    probe_t pe;
    @(posedge clk);
    cyc++;
    #1;
    reset       = rst;
    btn_c       = b;
    frame_begin = (cyc % FP == 0);
    if (rst) last_rst = cyc;
    if (fixed >= 0) pix = fixed;
    else begin
      case ($urandom_range(0, 7))
        0, 1:    pix = 6048 + int'($urandom_range(0, 95));
        2:       pix = int'($urandom_range(6144, 8191));
        default: pix = int'($urandom_range(0, 6143));
      endcase
    end
    pixel_index = 13'(pix);
    start_data  = 16'($urandom);
    rec_data    = 16'($urandom);
    done_data   = 16'($urandom);
    probe       = pr;
    if (pr) begin
      ph     = phase_at(cyc);
      pe.sel = sel_at(cyc);
      pe.x   = (pix < 6144) ? pix % 96 : 0;
      pe.y   = (pix < 6144) ? pix / 96 : 0;
      if (pix >= 6144) pe.data = 0;
      else if (pe.sel == 0 && ph == P_ARM && pe.y == 63 && pe.x < hold_at(cyc)) pe.data = 16'h07E0;
      else if (pe.sel == 1) pe.data = int'(rec_data);
      else if (pe.sel == 2) pe.data = int'(done_data);
      else pe.data = int'(start_data);
      pe.en   = (ph == P_REC) ? 1 : 0;
      pe.done = (cyc == a_d) ? 1 : 0;
      probe_q.push_back(pe);
    end
  endtask

  task automatic run_attempt(input int kind);
    int start;
    int g1;
    start  = cyc + 1;
    a_kind = kind;
    a_p    = start + int'($urandom_range(0, 60));
    a_f3   = (a_p / FP + 1) * FP + 2 * FP;
    a_d    = -1;
    a_g2   = -1;
    if (kind == 0) begin
      a_rl  = ($urandom_range(0, 2) == 0) ? a_f3 : a_p + 1 + int'($urandom_range(0, a_f3 - a_p - 1));
      a_end = a_rl + 5;
    end else if (kind == 3) begin
      a_r   = a_f3 + 1 + int'($urandom_range(0, 18));
      a_l   = a_r;
      a_end = a_r + 3;
    end else begin
      a_l = a_f3 + REC;
      if (kind == 2) begin
        a_q = a_f3 + 2 + int'($urandom_range(0, 20));
        a_a = a_f3 + 1 + int'($urandom_range(0, a_q - a_f3 - 2));
        if (a_q <= a_f3 + REC) a_l = a_q;
      end
      a_d   = a_l + 1;
      g1    = ((a_d + FP - 1) / FP) * FP;
      a_g2  = g1 + FP;
      a_rel = a_d + int'($urandom_range(1, 120));
      a_end = (a_g2 + FP + 2 > a_rel + 1) ? a_g2 + FP + 2 : a_rel + 1;
      done_q.push_back('{cyc: a_d, len: a_l - a_f3});
      scr_q.push_back('{cyc: g1 + 1, sel: 2});
      scr_q.push_back('{cyc: a_g2 + FP + 1, sel: 0});
    end
    for (int n = start; n <= a_end; n++) begin
      step(btn_at(n), (kind == 3 && n == a_r), (kind == 3 && n == a_r + 1) || ($urandom_range(0, 3) == 0), -1);
    end
  endtask

  always @(negedge clk) begin
    done_t  d;
    scr_t   s;
    probe_t pe;
    if (mon_on) begin
      if (rec_done) begin
        if (done_q.size() == 0) chk("unexpected_rec_done", 1, 0);
        else begin
          d = done_q.pop_front();
          chk("rec_done_cycle", cyc, d.cyc);
          chk("rec_en_length", run, d.len);
        end
      end
      if (rec_en) run++;
      else run = 0;
      if (int'(screen_sel) != last_sel) begin
        if (scr_q.size() == 0) chk("unexpected_screen_change", int'(screen_sel), last_sel);
        else begin
          s = scr_q.pop_front();
          chk("screen_change_cycle", cyc, s.cyc);
          chk("screen_change_value", int'(screen_sel), s.sel);
        end
        last_sel = int'(screen_sel);
      end
      if (probe) begin
        if (probe_q.size() == 0) chk("probe_queue_empty", 1, 0);
        else begin
          pe = probe_q.pop_front();
          chk("x", int'(x), pe.x);
          chk("y", int'(y), pe.y);
          chk("oled_data", int'(oled_data), pe.data);
          chk("rec_en", int'(rec_en), pe.en);
          chk("rec_done", int'(rec_done), pe.done);
          chk("screen_sel", int'(screen_sel), pe.sel);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    btn_c       = 1'b0;
    frame_begin = 1'b0;
    pixel_index = '0;
    start_data  = '0;
    rec_data    = '0;
    done_data   = '0;
    repeat (3) step(1'b0, 1'b1, 1'b0, -1);
    mon_on   = 1'b1;
    last_sel = 0;
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 95);
    step(1'b0, 1'b0, 1'b1, 96);
    step(1'b0, 1'b0, 1'b1, 6143);
    step(1'b0, 1'b0, 1'b1, 6144);
    for (int i = 0; i < 24; i++) run_attempt(i % 4);
    repeat (20) step(1'b0, 1'b0, 1'b1, -1);
    @(posedge clk);
    #1;
    probe = 1'b0;
    @(negedge clk);
    chk("done_queue_drained", done_q.size(), 0);
    chk("screen_queue_drained", scr_q.size(), 0);
    chk("probe_queue_drained", probe_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
